// File: rtl/qed_dup_sequencer_if.sv
// Fetch-side and qed-side signal bundle for the duplicate-stream sequencer.
// The master modport is the fetch/driver side and the slave modport is the sequencer.
interface qed_dup_sequencer_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 3
);
    logic [WIDTH-1:0]  ifu_instruction;
    logic              ifu_vld;
    logic              stall_IF;
    logic              dup_req;
    logic [WIDTH-1:0]  qed_instruction;
    logic              exec_dup;
    logic              qed_vld;
    logic              fetch_hold;
    logic [ADDR_W:0]   count;
    logic              replay_done;

    modport master (
        output ifu_instruction, ifu_vld, stall_IF, dup_req,
        input  qed_instruction, exec_dup, qed_vld, fetch_hold, count, replay_done
    );

    modport slave (
        input  ifu_instruction, ifu_vld, stall_IF, dup_req,
        output qed_instruction, exec_dup, qed_vld, fetch_hold, count, replay_done
    );
endinterface

// File: rtl/qed_dup_sequencer.sv
// Records original instructions into a FIFO, then replays them with exec_dup=1
// so the downstream qed transformer emits the duplicate stream.
module qed_dup_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    qed_dup_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {ST_RECORD, ST_REPLAY} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                exec_dup_q, replay_done_q;
    logic                push, pop, done_d;
    logic [WIDTH-1:0]    qed_instruction_c;
    logic                qed_vld_c, fetch_hold_c;

    // Next-state, push/pop decisions and combinational qed-side outputs.
    always_comb begin
        state_d           = state_q;
        count_d           = count_q;
        push              = 1'b0;
        pop               = 1'b0;
        done_d            = 1'b0;
        qed_instruction_c = bus.ifu_instruction;
        qed_vld_c         = bus.ifu_vld;
        fetch_hold_c      = 1'b0;

        // While rst is high the block behaves as a plain pass-through.
        if (!rst) begin
            unique case (state_q)
                ST_RECORD: begin
                    fetch_hold_c = (count_q == FULL);
                    push    = ena && bus.ifu_vld && !bus.stall_IF && (count_q < FULL);
                    count_d = count_q + CNT_W'(push);
                    // count_d != 0 covers both "already holding entries" and "pushing now".
                    if (ena && ((count_d == FULL) || (bus.dup_req && (count_d != '0)))) begin
                        state_d = ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    qed_instruction_c = mem[rd_ptr_q];
                    qed_vld_c         = 1'b1;
                    fetch_hold_c      = 1'b1;
                    pop     = ena && !bus.stall_IF && (count_q != '0);
                    count_d = count_q - CNT_W'(pop);
                    if (ena && (count_d == '0)) begin
                        state_d = ST_RECORD;
                        done_d  = pop;
                    end
                end
            endcase
        end
    end

    // State, pointers, occupancy and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RECORD;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            exec_dup_q    <= 1'b0;
            replay_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            exec_dup_q    <= (state_d == ST_REPLAY);
            replay_done_q <= done_d;
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.ifu_instruction;
    end

    assign bus.qed_instruction = qed_instruction_c;
    assign bus.qed_vld         = qed_vld_c;
    assign bus.fetch_hold      = fetch_hold_c;
    assign bus.exec_dup        = exec_dup_q;
    assign bus.replay_done     = replay_done_q;
    assign bus.count           = count_q;

    // Occupancy stays within 0..DEPTH.
    assert property (@(posedge clk) disable iff (rst) count_q <= FULL);
    assert property (@(posedge clk) disable iff (rst) !(pop && (count_q == '0)));
    assert property (@(posedge clk) disable iff (rst) !(push && (count_q == FULL)));
endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer: reset, record/replay, stall, full, ignored
// stimulus and reset in the middle of a replay.
module tb_qed_dup_sequencer;
    logic clk;
    logic rst;
    logic ena;
    int   checks = 0;
    int   errors = 0;

    qed_dup_sequencer_if #(.WIDTH(32), .ADDR_W(3)) bus ();

    qed_dup_sequencer #(.WIDTH(32), .DEPTH(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic vld, input logic stall,
                         input logic dreq);
        bus.ifu_instruction = instr;
        bus.ifu_vld         = vld;
        bus.stall_IF        = stall;
        bus.dup_req         = dreq;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);

        // 1: reset
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_exec_dup", 32'(bus.exec_dup), 32'd0);
        chk("rst_fetch_hold", 32'(bus.fetch_hold), 32'd0);
        chk("rst_replay_done", 32'(bus.replay_done), 32'd0);
        drive(32'h12345678, 1'b1, 1'b0, 1'b0);
        chk("rst_qed_vld_pass", 32'(bus.qed_vld), 32'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_qed_vld_low", 32'(bus.qed_vld), 32'd0);
        rst = 1'b0;

        // 2: pass-through, record two, replay two
        drive(32'h00700093, 1'b1, 1'b0, 1'b0);
        chk("pass_instr0", bus.qed_instruction, 32'h00700093);
        chk("pass_vld0", 32'(bus.qed_vld), 32'd1);
        tick();
        chk("rec_count1", 32'(bus.count), 32'd1);
        drive(32'h00708193, 1'b1, 1'b0, 1'b1);
        chk("pass_instr1", bus.qed_instruction, 32'h00708193);
        chk("rec_exec_dup_still0", 32'(bus.exec_dup), 32'd0);
        tick();
        drive(32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk("rec_count2", 32'(bus.count), 32'd2);
        chk("rep_exec_dup", 32'(bus.exec_dup), 32'd1);
        chk("rep_head0", bus.qed_instruction, 32'h00700093);
        chk("rep_vld", 32'(bus.qed_vld), 32'd1);
        chk("rep_fetch_hold", 32'(bus.fetch_hold), 32'd1);
        tick();
        chk("rep_count1", 32'(bus.count), 32'd1);
        chk("rep_head1", bus.qed_instruction, 32'h00708193);
        chk("rep_no_push", 32'(bus.count), 32'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rep_done_pulse", 32'(bus.replay_done), 32'd1);
        chk("rep_exec_dup_off", 32'(bus.exec_dup), 32'd0);
        chk("rep_count0", 32'(bus.count), 32'd0);
        chk("rec_fetch_hold_off", 32'(bus.fetch_hold), 32'd0);
        tick();
        chk("rep_done_single", 32'(bus.replay_done), 32'd0);

        // 3: stall during replay
        drive(32'h00A00513, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h00F02383, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h00B00593, 1'b1, 1'b0, 1'b1);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("stl_count3", 32'(bus.count), 32'd3);
        chk("stl_head_a", bus.qed_instruction, 32'h00A00513);
        tick();
        chk("stl_head_b", bus.qed_instruction, 32'h00F02383);
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("stl_hold1_head", bus.qed_instruction, 32'h00F02383);
        chk("stl_hold1_count", 32'(bus.count), 32'd2);
        tick();
        chk("stl_hold2_head", bus.qed_instruction, 32'h00F02383);
        chk("stl_hold2_count", 32'(bus.count), 32'd2);
        chk("stl_exec_dup", 32'(bus.exec_dup), 32'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stl_resume_head", bus.qed_instruction, 32'h00B00593);
        chk("stl_resume_count", 32'(bus.count), 32'd1);
        tick();
        chk("stl_done", 32'(bus.replay_done), 32'd1);
        chk("stl_exec_dup_off", 32'(bus.exec_dup), 32'd0);

        // 4: fill to DEPTH, automatic replay with pointer wrap
        for (int i = 0; i < 8; i++) begin
            drive(32'h10000000 + 32'(i * 32'h111), 1'b1, 1'b0, 1'b0);
            tick();
            if (i == 6) chk("full_count7", 32'(bus.count), 32'd7);
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("full_count8", 32'(bus.count), 32'd8);
        chk("full_fetch_hold", 32'(bus.fetch_hold), 32'd1);
        chk("full_exec_dup", 32'(bus.exec_dup), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_head%0d", i), bus.qed_instruction,
                32'h10000000 + 32'(i * 32'h111));
            chk($sformatf("full_cnt%0d", i), 32'(bus.count), 32'(8 - i));
            tick();
        end
        chk("full_done", 32'(bus.replay_done), 32'd1);
        chk("full_count0", 32'(bus.count), 32'd0);
        chk("full_exec_dup_off", 32'(bus.exec_dup), 32'd0);

        // 5: ignored stimulus
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ign_dupreq_state", 32'(bus.exec_dup), 32'd0);
        chk("ign_dupreq_count", 32'(bus.count), 32'd0);
        drive(32'h0BADC0DE, 1'b1, 1'b1, 1'b1);
        chk("ign_stall_pass", 32'(bus.qed_vld), 32'd1);
        tick();
        tick();
        chk("ign_stall_count", 32'(bus.count), 32'd0);
        chk("ign_stall_state", 32'(bus.exec_dup), 32'd0);
        ena = 1'b0;
        drive(32'h0BADC0DE, 1'b1, 1'b0, 1'b0);
        tick();
        chk("ena0_no_push", 32'(bus.count), 32'd0);
        ena = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);

        // 6: reset mid-replay, then next push lands at entry 0
        for (int i = 0; i < 8; i++) begin
            drive(32'h20000000 + 32'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("mid_count5", 32'(bus.count), 32'd5);
        chk("mid_head3", bus.qed_instruction, 32'h20000003);
        rst = 1'b1;
        #1;
        chk("mid_rst_fetch_hold", 32'(bus.fetch_hold), 32'd0);
        chk("mid_rst_qed_vld", 32'(bus.qed_vld), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_count0", 32'(bus.count), 32'd0);
        chk("mid_exec_dup0", 32'(bus.exec_dup), 32'd0);
        chk("mid_fetch_hold0", 32'(bus.fetch_hold), 32'd0);
        drive(32'hCAFE0001, 1'b1, 1'b0, 1'b1);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_count1", 32'(bus.count), 32'd1);
        chk("post_exec_dup", 32'(bus.exec_dup), 32'd1);
        chk("post_head_entry0", bus.qed_instruction, 32'hCAFE0001);
        tick();
        chk("post_done", 32'(bus.replay_done), 32'd1);
        chk("post_count0", 32'(bus.count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
